// File: rtl/cpu_sequencer.sv
// CPU phase sequencer: streams a program image into program memory, then runs
// the FETCH/DECODE/EXECUTE loop with halt, single-step, breakpoint and reload.
module cpu_sequencer #(
  parameter int ADDR_W     = 8,
  parameter int LOAD_WORDS = 256,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_valid,
  input  logic [11:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              pmem_we,
  output logic [ADDR_W-1:0] pmem_waddr,
  output logic [11:0]       pmem_wdata,
  input  logic              run_en,
  input  logic              halt_req,
  input  logic              step_req,
  input  logic              reload_req,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] pc,
  output logic [1:0]        present_state,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [ADDR_W:0]   load_count,
  output logic [CNT_W-1:0]  instr_count
);

  typedef enum logic [1:0] {
    ST_LOAD    = 2'b00,
    ST_FETCH   = 2'b01,
    ST_DECODE  = 2'b10,
    ST_EXECUTE = 2'b11
  } state_t;

  localparam logic [ADDR_W:0]  LAST_IDX = (ADDR_W+1)'(LOAD_WORDS - 1);
  localparam logic [ADDR_W:0]  LC_ONE   = (ADDR_W+1)'(1);
  localparam logic [CNT_W-1:0] IC_ONE   = CNT_W'(1);

  localparam logic [1:0] CAUSE_RUN  = 2'b00;
  localparam logic [1:0] CAUSE_HALT = 2'b01;
  localparam logic [1:0] CAUSE_BP   = 2'b10;
  localparam logic [1:0] CAUSE_STEP = 2'b11;

  state_t             state_q, state_d;
  logic               load_ready_q, load_ready_d;
  logic               halted_q, halted_d;
  logic [1:0]         halt_cause_q, halt_cause_d;
  logic [ADDR_W:0]    load_count_q, load_count_d;
  logic [CNT_W-1:0]   instr_count_q, instr_count_d;
  logic               halt_flag_q, halt_flag_d;
  logic               step_flag_q, step_flag_d;

  logic accept;
  logic halt_pending;
  logic bp_hit;

  always_comb begin
    state_d       = state_q;
    load_ready_d  = load_ready_q;
    halted_d      = halted_q;
    halt_cause_d  = halt_cause_q;
    load_count_d  = load_count_q;
    instr_count_d = instr_count_q;
    step_flag_d   = step_flag_q;
    // A halt request in the current cycle counts as pending so a pulse landing
    // on a FETCH still takes effect there.
    halt_pending  = halt_flag_q | halt_req;
    halt_flag_d   = halt_pending;
    accept        = (state_q == ST_LOAD) & load_valid & load_ready_q;
    bp_hit        = bp_en & (pc == bp_addr);

    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          load_count_d = load_count_q + LC_ONE;
          if (load_last || (load_count_q == LAST_IDX)) begin
            load_ready_d = 1'b0;
            state_d      = ST_FETCH;
            if (!run_en) begin
              halted_d     = 1'b1;
              halt_cause_d = CAUSE_RUN;
            end
          end
        end else if (!load_ready_q) begin
          load_ready_d = 1'b1;
        end
      end
      ST_FETCH: begin
        if (halted_q) begin
          // Leaving halted goes straight to DECODE, so the breakpoint is never
          // re-evaluated for the instruction being resumed.
          if (halt_pending) begin
            halt_cause_d = CAUSE_HALT;
            halt_flag_d  = 1'b0;
          end else if (reload_req) begin
            state_d      = ST_LOAD;
            load_count_d = '0;
            load_ready_d = 1'b1;
            halted_d     = 1'b0;
            step_flag_d  = 1'b0;
          end else if (step_req) begin
            halted_d    = 1'b0;
            step_flag_d = 1'b1;
            state_d     = ST_DECODE;
          end else if (run_en) begin
            halted_d = 1'b0;
            state_d  = ST_DECODE;
          end
        end else if (halt_pending) begin
          halted_d     = 1'b1;
          halt_cause_d = CAUSE_HALT;
          halt_flag_d  = 1'b0;
          step_flag_d  = 1'b0;
        end else if (step_flag_q) begin
          halted_d     = 1'b1;
          halt_cause_d = CAUSE_STEP;
          step_flag_d  = 1'b0;
        end else if (bp_hit) begin
          halted_d     = 1'b1;
          halt_cause_d = CAUSE_BP;
        end else if (!run_en) begin
          halted_d     = 1'b1;
          halt_cause_d = CAUSE_RUN;
        end else begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        state_d = ST_FETCH;
        if (instr_count_q != '1) instr_count_d = instr_count_q + IC_ONE;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_LOAD;
      load_ready_q  <= 1'b0;
      halted_q      <= 1'b0;
      halt_cause_q  <= CAUSE_RUN;
      load_count_q  <= '0;
      instr_count_q <= '0;
      halt_flag_q   <= 1'b0;
      step_flag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_ready_q  <= load_ready_d;
      halted_q      <= halted_d;
      halt_cause_q  <= halt_cause_d;
      load_count_q  <= load_count_d;
      instr_count_q <= instr_count_d;
      halt_flag_q   <= halt_flag_d;
      step_flag_q   <= step_flag_d;
    end
  end

  assign pmem_we       = accept & ~rst;
  assign pmem_waddr    = load_count_q[ADDR_W-1:0];
  assign pmem_wdata    = load_data;
  assign load_ready    = load_ready_q;
  assign present_state = state_q;
  assign halted        = halted_q;
  assign halt_cause    = halt_cause_q;
  assign load_count    = load_count_q;
  assign instr_count   = instr_count_q;

endmodule
